// File: rtl/neuron_mac.sv
// Serial multiply-accumulate for one neuron: bias plus N_INPUTS signed 8x8 products,
// saturated per beat into a 21-bit signed sum handed to the activation stage.
module neuron_mac #(
  parameter int N_INPUTS = 64,
  parameter int CNT_W    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [20:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  x_in,
  input  logic [7:0]  w_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [20:0] sum_out,
  output logic        sat,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  state_t             state_q, state_d;
  logic [20:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic signed [15:0] prod;
  logic signed [21:0] nxt;
  logic               accept;

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum_out   = acc_q;
  assign sat       = sat_q;
  assign accept    = in_valid & in_ready;

  always_comb begin
    prod    = $signed(x_in) * $signed(w_in);
    nxt     = $signed({acc_q[20], acc_q}) + $signed({{6{prod[15]}}, prod});
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d   = bias;
        cnt_d   = '0;
        sat_d   = 1'b0;
        state_d = ACC;
      end
      ACC: if (accept) begin
        // Bits 21 and 20 disagree exactly when the 22-bit sum leaves the 21-bit range.
        if (nxt[21] != nxt[20]) begin
          acc_d = nxt[21] ? 21'h100000 : 21'h0FFFFF;
          sat_d = 1'b1;
        end else begin
          acc_d = nxt[20:0];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac with N_INPUTS=4: expected sums are modelled as beats
// are driven and compared when the result handshake appears.
module tb_neuron_mac;
  localparam int N = 4;

  typedef int vec_t [N];
  typedef struct { int sum; int sat; } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, out_valid, out_ready, sat, busy;
  logic [20:0] bias, sum_out;
  logic [7:0]  x_in, w_in;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  neuron_mac #(.N_INPUTS(N), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
    .sat(sat), .busy(busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int ssum();
    return int'($signed(sum_out));
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_sum"}, ssum(), 0);
    chk({tag, "_sat"}, sat, 0);
  endtask

  // One full evaluation: gap idle cycles before each beat, optional start pulses in ACC
  // and at the DONE->IDLE handoff, and hold cycles of backpressure in DONE.
  task automatic run(input int b, input vec_t xs, input vec_t ws, input int gap,
                     input bit start_acc, input int hold, input bit start_ho,
                     input bit chk_lat);
    int   ea, es, lat, cyc;
    exp_t e;
    ea = b; es = 0;
    bias = 21'(b); start = 1'b1;
    tick;
    start = 1'b0; lat = 1;
    chk("rdy_rise", in_ready, 1);
    chk("busy_acc", busy, 1);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0; start = start_acc;
        tick;
        start = 1'b0; lat++;
        if (start_acc) chk("acc_start_ign", in_ready, 1);
      end
      x_in = 8'(xs[i]); w_in = 8'(ws[i]); in_valid = 1'b1;
      tick;
      in_valid = 1'b0; lat++;
      ea += xs[i] * ws[i];
      if (ea > 1048575)       begin ea = 1048575;  es = 1; end
      else if (ea < -1048576) begin ea = -1048576; es = 1; end
    end
    sb.push_back('{ea, es});
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick; cyc++; lat++;
    end
    chk("out_timeout", out_valid, 1);
    if (chk_lat) chk("latency", lat, N + 1);
    e = sb.pop_front();
    chk("sum", ssum(), e.sum);
    chk("sat", sat, e.sat);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; x_in = 8'd100; w_in = 8'd100;
      tick;
      chk("dn_vld", out_valid, 1);
      chk("dn_rdy", in_ready, 0);
      chk("dn_sum", ssum(), e.sum);
    end
    in_valid = 1'b0; out_ready = 1'b1; start = start_ho;
    tick;
    out_ready = 1'b0; start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("ov_clr", out_valid, 0);
    chk("hold_sum", ssum(), e.sum);
    chk("hold_sat", sat, e.sat);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bias = '0; x_in = '0; w_in = '0;
    tick; tick;
    chk_reset_state("rst");
    rst = 1'b0;
    tick;
    chk_reset_state("idle");

    run(0,        '{10, 10, 10, 10},   '{20, 20, 20, 20},     0, 0, 0, 0, 1);
    run(-1000,    '{5, 127, 0, -2},    '{-7, 3, 100, -50},    0, 0, 0, 0, 0);
    run(1048000,  '{127, 127, 127, 127}, '{127, 127, 127, 127}, 0, 0, 0, 0, 0);
    run(-1048000, '{127, 127, 127, 127}, '{-127, -127, -127, -127}, 0, 0, 0, 0, 0);
    // rail recovery: clamp high on first beat, then pull back off the rail
    run(1048570,  '{-128, -128, 1, 0}, '{-128, 1, 1, 0},     0, 0, 0, 0, 0);
    run(12345,    '{1, -3, 90, 7},     '{2, 4, -90, 9},       2, 0, 10, 0, 0);

    // abort mid-ACC after two beats
    bias = 21'd500000; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x_in = 8'd50; w_in = 8'd50; in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_reset_state("abort");
    run(7, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 0, 0, 0, 0);

    // start pulses in ACC and at handoff are ignored; next IDLE-cycle start is taken
    run(100, '{3, 4, 5, 6}, '{-1, -2, -3, -4}, 1, 1, 2, 1, 0);
    run(-5,  '{-128, 2, 0, 1}, '{-128, 2, 9, -1}, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
